// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects ten slide switches and two active-low keys,
// and adds a per-key press/hold state machine with single-cycle event pulses.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic       max10_clk1_50,
  input  logic       reset,
  input  logic [9:0] sw,
  input  logic [1:0] key,
  output logic [9:0] sw_db,
  output logic [1:0] key_down,
  output logic [1:0] key_press,
  output logic [1:0] key_release,
  output logic [1:0] key_hold,
  output logic [9:0] sw_change
);

  localparam int N_IN   = 12;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  // Bits [11:10] are the keys, whose released level is 1.
  localparam logic [N_IN-1:0] IDLE_LEVEL = {2'b11, 10'b00_0000_0000};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_t;

  logic [N_IN-1:0]   raw_s;
  logic [N_IN-1:0]   sync1_r;
  logic [N_IN-1:0]   sync2_r;
  logic [N_IN-1:0]   stable_r;
  logic [N_IN-1:0]   accept_s;
  logic [DB_W-1:0]   db_cnt_r     [N_IN];
  logic [DB_W-1:0]   db_cnt_nxt_s [N_IN];
  logic [9:0]        sw_change_r;

  key_state_t        state_r      [2];
  key_state_t        state_nxt_s  [2];
  logic [HOLD_W-1:0] hold_cnt_r   [2];
  logic [HOLD_W-1:0] hold_nxt_s   [2];
  logic [1:0]        press_evt_s;
  logic [1:0]        release_evt_s;
  logic [1:0]        hold_evt_s;
  logic [1:0]        key_down_r;
  logic [1:0]        key_press_r;
  logic [1:0]        key_release_r;
  logic [1:0]        key_hold_r;

  assign raw_s = {key, sw};

  // Two-flop synchronizer for all raw inputs
  always_ff @(posedge max10_clk1_50) begin
    if (reset) begin
      sync1_r <= IDLE_LEVEL;
      sync2_r <= IDLE_LEVEL;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-input debounce counter next state and level acceptance
  always_comb begin
    accept_s = {N_IN{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      db_cnt_nxt_s[i] = {DB_W{1'b0}};
      if (sync2_r[i] == stable_r[i]) begin
        db_cnt_nxt_s[i] = {DB_W{1'b0}};
      end else if (db_cnt_r[i] == DB_MAX) begin
        accept_s[i]     = 1'b1;
        db_cnt_nxt_s[i] = {DB_W{1'b0}};
      end else begin
        db_cnt_nxt_s[i] = db_cnt_r[i] + DB_W'(1);
      end
    end
  end

  // Debounce counters, stable levels and switch change pulses
  always_ff @(posedge max10_clk1_50) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) begin
        db_cnt_r[i] <= {DB_W{1'b0}};
      end
      stable_r    <= IDLE_LEVEL;
      sw_change_r <= 10'b00_0000_0000;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        db_cnt_r[i] <= db_cnt_nxt_s[i];
      end
      stable_r    <= stable_r ^ accept_s;
      sw_change_r <= accept_s[9:0];
    end
  end

  // An accepted key edge is a press when the key was released (stable 1) beforehand.
  assign press_evt_s   = accept_s[11:10] & stable_r[11:10];
  assign release_evt_s = accept_s[11:10] & ~stable_r[11:10];

  // Key FSM next state; release wins over the hold transition
  always_comb begin
    hold_evt_s = 2'b00;
    for (int k = 0; k < 2; k++) begin
      state_nxt_s[k] = state_r[k];
      hold_nxt_s[k]  = hold_cnt_r[k];
      case (state_r[k])
        IDLE: begin
          if (press_evt_s[k]) begin
            state_nxt_s[k] = PRESSED;
            hold_nxt_s[k]  = {HOLD_W{1'b0}};
          end else begin
            state_nxt_s[k] = IDLE;
          end
        end
        PRESSED: begin
          if (release_evt_s[k]) begin
            state_nxt_s[k] = IDLE;
            hold_nxt_s[k]  = {HOLD_W{1'b0}};
          end else if (hold_cnt_r[k] == HOLD_MAX) begin
            state_nxt_s[k] = HELD;
            hold_evt_s[k]  = 1'b1;
          end else begin
            hold_nxt_s[k] = hold_cnt_r[k] + HOLD_W'(1);
          end
        end
        HELD: begin
          if (release_evt_s[k]) begin
            state_nxt_s[k] = IDLE;
            hold_nxt_s[k]  = {HOLD_W{1'b0}};
          end else begin
            state_nxt_s[k] = HELD;
          end
        end
        default: begin
          state_nxt_s[k] = IDLE;
          hold_nxt_s[k]  = {HOLD_W{1'b0}};
        end
      endcase
    end
  end

  // Key FSM state, hold counters and registered key outputs
  always_ff @(posedge max10_clk1_50) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        state_r[k]    <= IDLE;
        hold_cnt_r[k] <= {HOLD_W{1'b0}};
        key_down_r[k] <= 1'b0;
      end
      key_press_r   <= 2'b00;
      key_release_r <= 2'b00;
      key_hold_r    <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_r[k]    <= state_nxt_s[k];
        hold_cnt_r[k] <= hold_nxt_s[k];
        key_down_r[k] <= (state_nxt_s[k] != IDLE);
      end
      key_press_r   <= press_evt_s;
      key_release_r <= release_evt_s;
      key_hold_r    <= hold_evt_s;
    end
  end

  assign sw_db       = stable_r[9:0];
  assign sw_change   = sw_change_r;
  assign key_down    = key_down_r;
  assign key_press   = key_press_r;
  assign key_release = key_release_r;
  assign key_hold    = key_hold_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sw;
  logic [1:0] key;
  logic [9:0] sw_db;
  logic [1:0] key_down;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] key_hold;
  logic [9:0] sw_change;

  int cyc     = 0;
  int n_check = 0;
  int n_fail  = 0;

  typedef struct {
    int         at;
    logic [9:0] swc;
    logic [9:0] swdb;
    logic [1:0] kp;
    logic [1:0] kr;
    logic [1:0] kh;
    logic [1:0] kd;
  } exp_t;

  exp_t exp_q[$];

  input_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20)) dut (
    .max10_clk1_50(clk),
    .reset        (reset),
    .sw           (sw),
    .key          (key),
    .sw_db        (sw_db),
    .key_down     (key_down),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_hold     (key_hold),
    .sw_change    (sw_change)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with a pulse must match the next expected event
  always @(negedge clk) begin
    exp_t e;
    if ((sw_change != 10'd0) || (key_press != 2'd0) || (key_release != 2'd0) || (key_hold != 2'd0)) begin
      n_check++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d got swc=%h kp=%b kr=%b kh=%b, required no pulse",
                 cyc, sw_change, key_press, key_release, key_hold);
      end else begin
        e = exp_q.pop_front();
        if (e.at != cyc || e.swc != sw_change || e.swdb != sw_db || e.kp != key_press ||
            e.kr != key_release || e.kh != key_hold || e.kd != key_down) begin
          n_fail++;
          $display("FAIL pulse_event got cyc=%0d swc=%h swdb=%h kp=%b kr=%b kh=%b kd=%b required cyc=%0d swc=%h swdb=%h kp=%b kr=%b kh=%b kd=%b",
                   cyc, sw_change, sw_db, key_press, key_release, key_hold, key_down,
                   e.at, e.swc, e.swdb, e.kp, e.kr, e.kh, e.kd);
        end
      end
    end
  end

  task automatic push(input int at, input logic [9:0] swc, input logic [9:0] swdb,
                      input logic [1:0] kp, input logic [1:0] kr, input logic [1:0] kh,
                      input logic [1:0] kd);
    exp_t e;
    e.at = at; e.swc = swc; e.swdb = swdb; e.kp = kp; e.kr = kr; e.kh = kh; e.kd = kd;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_check++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw_db"},       {6'd0, sw_db},        16'd0);
    check({tag, "_key_down"},    {14'd0, key_down},    16'd0);
    check({tag, "_key_press"},   {14'd0, key_press},   16'd0);
    check({tag, "_key_release"}, {14'd0, key_release}, 16'd0);
    check({tag, "_key_hold"},    {14'd0, key_hold},    16'd0);
    check({tag, "_sw_change"},   {6'd0, sw_change},    16'd0);
  endtask

  initial begin
    reset = 1'b1;
    sw    = 10'd0;
    key   = 2'b11;
    wait_cyc(2);
    check_all_zero("reset");
    reset = 1'b0;
    wait_cyc(2);

    // Switch 3 up then down: change lands 6 edges after the drive
    sw = 10'h008;
    push(cyc + 6, 10'h008, 10'h008, 2'b00, 2'b00, 2'b00, 2'b00);
    wait_cyc(5);
    check("sw3_not_yet", {6'd0, sw_db}, 16'h0000);
    wait_cyc(5);
    check("sw3_up", {6'd0, sw_db}, 16'h0008);
    sw = 10'h000;
    push(cyc + 6, 10'h008, 10'h000, 2'b00, 2'b00, 2'b00, 2'b00);
    wait_cyc(10);

    // Key 0 glitch of 3 cycles: filtered out
    key = 2'b10;
    wait_cyc(3);
    key = 2'b11;
    wait_cyc(12);
    check("glitch_key_down", {14'd0, key_down}, 16'h0000);

    // Key 1 held 30 cycles: press, hold 20 later, release
    key = 2'b01;
    push(cyc + 6,  10'h000, 10'h000, 2'b10, 2'b00, 2'b00, 2'b10);
    push(cyc + 26, 10'h000, 10'h000, 2'b00, 2'b00, 2'b10, 2'b10);
    wait_cyc(30);
    key = 2'b11;
    push(cyc + 6, 10'h000, 10'h000, 2'b00, 2'b10, 2'b00, 2'b00);
    wait_cyc(10);
    check("key1_released", {14'd0, key_down}, 16'h0000);

    // Both keys on the same edge
    key = 2'b00;
    push(cyc + 6, 10'h000, 10'h000, 2'b11, 2'b00, 2'b00, 2'b11);
    wait_cyc(10);
    check("both_down", {14'd0, key_down}, 16'h0003);
    key = 2'b11;
    push(cyc + 6, 10'h000, 10'h000, 2'b00, 2'b11, 2'b00, 2'b00);
    wait_cyc(10);

    // Switch and key simultaneously
    sw  = 10'h020;
    key = 2'b01;
    push(cyc + 6, 10'h020, 10'h020, 2'b10, 2'b00, 2'b00, 2'b10);
    wait_cyc(10);
    sw  = 10'h000;
    key = 2'b11;
    push(cyc + 6, 10'h020, 10'h000, 2'b00, 2'b10, 2'b00, 2'b00);
    wait_cyc(10);

    // Release lands on the exact hold edge: release wins, no hold pulse
    key = 2'b10;
    push(cyc + 6, 10'h000, 10'h000, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_cyc(20);
    key = 2'b11;
    push(cyc + 6, 10'h000, 10'h000, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_cyc(40);

    // Reset 10 cycles into PRESSED: everything clears, no later pulses
    key = 2'b10;
    push(cyc + 6, 10'h000, 10'h000, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_cyc(16);
    check("pre_reset_down", {14'd0, key_down}, 16'h0001);
    reset = 1'b1;
    key   = 2'b11;
    wait_cyc(1);
    check_all_zero("midhold_reset");
    reset = 1'b0;
    wait_cyc(30);

    // Switch already up through reset is accepted afterwards
    sw    = 10'h001;
    reset = 1'b1;
    wait_cyc(1);
    check("sw_up_in_reset", {6'd0, sw_db}, 16'h0000);
    reset = 1'b0;
    push(cyc + 6, 10'h001, 10'h001, 2'b00, 2'b00, 2'b00, 2'b00);
    wait_cyc(10);
    sw = 10'h000;
    push(cyc + 6, 10'h001, 10'h000, 2'b00, 2'b00, 2'b00, 2'b00);
    wait_cyc(10);

    // Switch chatter every 2 cycles for 40 cycles: never accepted
    for (int t = 0; t < 20; t++) begin
      sw = sw ^ 10'h3FF;
      wait_cyc(2);
    end
    wait_cyc(10);
    check("chatter_sw_db", {6'd0, sw_db}, 16'h0000);

    check("events_outstanding", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
